// File: rtl/bp_pkg.sv
// Shared branch predictor types: BHT counter encoding, predictor FSM
// states, and the conditional-branch func3 encoding used by the comparator.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bp_state_t;

    localparam bht_ctr_t BHT_RESET = WNT;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_func3_t;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating counter next-state logic (purely combinational).
// Ports: cur (current counter), taken (resolved outcome), nxt (updated counter).
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    bht_ctr_t c;
    bht_ctr_t n;

    assign c   = bht_ctr_t'(cur);
    assign nxt = n;

    always_comb begin
        n = c;
        unique case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal direction predictor with EX-stage training, mispredict redirect
// and multi-cycle flush.
// Ports: clk/rstN; IF lookup (if_valid, if_pc -> pred_taken);
// EX resolve (ex_valid, ex_pc, ex_pred_taken, ex_taken, ex_target);
// redirect_valid/redirect_pc, flush; br_count/mispred_count statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES      = 64,
    parameter int IDX_W        = $clog2(ENTRIES),
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [1:0]       bht [ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       upd;

    bp_state_t        state, state_n;
    logic [FC_W-1:0]  fcnt, fcnt_n;
    logic             accept;
    logic             mis;
    logic             unused_pc;

    assign if_idx    = if_pc[IDX_W+1:2];
    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Table read returns the pre-update value on a same-index write.
    assign pred_taken = if_valid & bht[if_idx][1];
    assign flush      = (state == FLUSH);

    sat_ctr2 u_ctr (
        .cur   (bht[ex_idx]),
        .taken (ex_taken),
        .nxt   (upd)
    );

    // EX results seen while flushing are wrong-path and are dropped.
    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        accept  = 1'b0;
        mis     = 1'b0;
        unique case (state)
            IDLE: begin
                accept = ex_valid;
                mis    = ex_valid && (ex_taken != ex_pred_taken);
                if (mis) begin
                    state_n = FLUSH;
                    fcnt_n  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt == '0) begin
                    state_n = IDLE;
                end else begin
                    fcnt_n = fcnt - FC_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= BHT_RESET;
            end
        end else if (accept) begin
            bht[ex_idx] <= upd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            redirect_valid <= mis;
            if (mis) begin
                redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
            end
            if (accept && br_count != '1) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mis && mispred_count != '1) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: redirect scoreboard plus
// inline checks of prediction, flush timing and statistics.
module tb_branch_predictor;

    logic        clk;
    logic        rstN;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    logic        pred4;
    logic        rv4;
    logic [31:0] rpc4;
    logic        flush4;
    logic [3:0]  br4;
    logic [3:0]  mis4;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    branch_predictor dut (
        .clk            (clk),
        .rstN           (rstN),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    branch_predictor #(.CNT_W(4)) dut4 (
        .clk            (clk),
        .rstN           (rstN),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred4),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .redirect_valid (rv4),
        .redirect_pc    (rpc4),
        .flush          (flush4),
        .br_count       (br4),
        .mispred_count  (mis4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every redirect pulse must match the oldest
    // expected redirect target.
    always @(negedge clk) begin
        if (redirect_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected: got pc 0x%08h expected none",
                         redirect_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (redirect_pc !== e) begin
                    errors++;
                    $display("FAIL redirect_pc: got 0x%08h expected 0x%08h",
                             redirect_pc, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one resolved branch for a cycle; push the expected redirect
    // target if this branch should redirect.
    task automatic br(input logic [31:0] pc, input logic pred,
                      input logic taken, input logic [31:0] tgt,
                      input logic exp_redir, input logic [31:0] exp_pc);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_pred_taken = pred;
        ex_taken      = taken;
        ex_target     = tgt;
        if (exp_redir) exp_q.push_back(exp_pc);
        step();
        ex_valid = 1'b0;
    endtask

    initial begin
        rstN          = 1'b0;
        if_valid      = 1'b0;
        if_pc         = '0;
        ex_valid      = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        ex_taken      = 1'b0;
        ex_target     = '0;
        repeat (2) step();
        rstN = 1'b1;

        // 1: reset state
        if_valid = 1'b1;
        if_pc    = 32'h100;
        #1;
        chk("reset_pred", {31'd0, pred_taken}, 32'd0);
        chk("reset_rv", {31'd0, redirect_valid}, 32'd0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_rpc", redirect_pc, 32'd0);
        chk("reset_br", br_count, 32'd0);
        chk("reset_mis", mispred_count, 32'd0);
        if_valid = 1'b0;
        #1;
        chk("pred_no_valid", {31'd0, pred_taken}, 32'd0);
        if_valid = 1'b1;

        // 2: train 0x40 taken x3 (first one mispredicts from WNT)
        if_pc = 32'h40;
        br(32'h40, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        repeat (2) step();
        chk("train1_pred", {31'd0, pred_taken}, 32'd1);
        br(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("train2_pred", {31'd0, pred_taken}, 32'd1);
        br(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("train3_sat_pred", {31'd0, pred_taken}, 32'd1);
        if_pc = 32'h140;
        #1;
        chk("alias_140_pred", {31'd0, pred_taken}, 32'd1);
        chk("train_br", br_count, 32'd3);
        chk("train_mis", mispred_count, 32'd1);

        // 3: taken mispredict redirects to target, flush for 2 cycles
        if_pc = 32'h200;
        #1;
        chk("pc200_pred", {31'd0, pred_taken}, 32'd0);
        br(32'h200, 1'b0, 1'b1, 32'h180, 1'b1, 32'h180);
        chk("mis3_rv", {31'd0, redirect_valid}, 32'd1);
        chk("mis3_flush1", {31'd0, flush}, 32'd1);
        chk("mis3_count", mispred_count, 32'd2);
        step();
        chk("mis3_flush2", {31'd0, flush}, 32'd1);
        chk("mis3_rv_drop", {31'd0, redirect_valid}, 32'd0);
        step();
        chk("mis3_flush_end", {31'd0, flush}, 32'd0);

        // 4: not-taken mispredict at top of memory wraps to 0
        br(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234, 1'b1, 32'h0);
        chk("wrap_rpc", redirect_pc, 32'h0);
        repeat (2) step();
        chk("wrap_br", br_count, 32'd5);
        chk("wrap_mis", mispred_count, 32'd3);

        // 5: branches during FLUSH are ignored
        br(32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 32'h304);
        br(32'h40, 1'b1, 1'b0, 32'h900, 1'b0, 32'h0);
        chk("fl_ign_rv1", {31'd0, redirect_valid}, 32'd0);
        br(32'h40, 1'b1, 1'b0, 32'h900, 1'b0, 32'h0);
        chk("fl_ign_rv2", {31'd0, redirect_valid}, 32'd0);
        chk("fl_ign_br", br_count, 32'd6);
        chk("fl_ign_mis", mispred_count, 32'd4);
        if_pc = 32'h40;
        #1;
        chk("fl_ign_pred40", {31'd0, pred_taken}, 32'd1);
        br(32'h500, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600);
        chk("post_fl_rv", {31'd0, redirect_valid}, 32'd1);
        chk("post_fl_mis", mispred_count, 32'd5);

        // 6: reset during the first flush cycle
        rstN = 1'b0;
        step();
        chk("rst_fl_flush", {31'd0, flush}, 32'd0);
        chk("rst_fl_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_fl_rpc", redirect_pc, 32'd0);
        chk("rst_fl_br", br_count, 32'd0);
        chk("rst_fl_mis", mispred_count, 32'd0);
        chk("rst_fl_pred40", {31'd0, pred_taken}, 32'd0);
        rstN = 1'b1;
        step();

        // 7: 16 correctly predicted branches saturate a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            br(32'h800, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        chk("cnt4_sat", {28'd0, br4}, 32'h0000_000F);
        chk("cnt32_br", br_count, 32'd16);
        chk("cnt32_mis", mispred_count, 32'd0);

        step();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
